busca_instrucao: RTL and testbench

Instruction fetch stage of the multi-cycle processor; sits directly upstream of the control decoder. Holds the PC and fetches 16-bit instructions from an external instruction memory over a req/ack handshake. Latches each instruction into an instruction register and presents its 3-bit OpCode to the decoder. Computes the next PC from the decoder's Halt/Beq/Salto signals and the ALU zero flag once execute reports completion.

---
 rtl/proc_pkg.sv | 26 ++
 rtl/proximo_pc.sv | 34 +++
 rtl/busca_instrucao.sv | 89 ++++++++
 tb/tb_busca_instrucao.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared processor definitions: opcodes, fetch FSM states and instruction field positions.
package proc_pkg;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_SW  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_BEQ = 3'b011;
  localparam logic [2:0] OP_J   = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_HLT = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALTED = 3'd4
  } fetch_state_t;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 13;
  localparam int OFF_MSB = 6;
  localparam int OFF_LSB = 0;
  localparam int OFF_W   = OFF_MSB - OFF_LSB + 1;

endpackage

// File: rtl/proximo_pc.sv
// Next-PC selection: Halt > Salto > Beq&zero > pc+1, all modulo 2^PC_W.
// Purely combinational.
module proximo_pc
  import proc_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic [PC_W-1:0] pc,
  input  logic [15:0]     instr,
  input  logic            halt,
  input  logic            beq,
  input  logic            salto,
  input  logic            zero,
  output logic [PC_W-1:0] next_pc
);

  // Extend to the full word first so narrow PC widths (below 7 bits) still truncate cleanly.
  logic [15:0] off_ext;
  assign off_ext = {{(16-OFF_W){instr[OFF_MSB]}}, instr[OFF_MSB:OFF_LSB]};

  logic unused_bits;
  assign unused_bits = &{1'b0, instr[15:PC_W], off_ext[15:PC_W]};

  always_comb begin
    next_pc = pc + PC_W'(1);
    if (halt)
      next_pc = pc;
    else if (salto)
      next_pc = instr[PC_W-1:0];
    else if (beq && zero)
      next_pc = pc + PC_W'(1) + off_ext[PC_W-1:0];
  end

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch stage: PC, req/ack fetch, instruction register and next-PC update.
// Optional FETCH_COUNT_EN adds the instr_count issued-instruction counter port.
module busca_instrucao
  import proc_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  output logic [15:0]     instr,
  output logic [2:0]      OpCode,
  output logic            instr_valid,
  input  logic            exec_done,
  input  logic            Halt,
  input  logic            Beq,
  input  logic            Salto,
  input  logic            zero,
  output logic [PC_W-1:0] pc,
  output logic            halted
`ifdef FETCH_COUNT_EN
  ,
  output logic [15:0]     instr_count
`endif
);

  fetch_state_t    state, state_nxt;
  logic [PC_W-1:0] pc_nxt;

  proximo_pc #(.PC_W(PC_W)) u_proximo_pc (
    .pc      (pc),
    .instr   (instr),
    .halt    (Halt),
    .beq     (Beq),
    .salto   (Salto),
    .zero    (zero),
    .next_pc (pc_nxt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   state_nxt = ST_FETCH;
      ST_FETCH:  if (imem_ack) state_nxt = ST_ISSUE;
      ST_ISSUE:  state_nxt = ST_EXEC;
      ST_EXEC:   if (exec_done) state_nxt = Halt ? ST_HALTED : ST_FETCH;
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs are flopped from the next state so they line up with the state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      instr       <= 16'h0000;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state       <= state_nxt;
      imem_req    <= (state_nxt == ST_FETCH);
      instr_valid <= (state_nxt == ST_ISSUE);
      halted      <= (state_nxt == ST_HALTED);
      if (state == ST_FETCH && imem_ack)
        instr <= imem_data;
      if (state == ST_EXEC && exec_done)
        pc <= pc_nxt;
    end
  end

`ifdef FETCH_COUNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      instr_count <= 16'h0000;
    else if (state == ST_ISSUE)
      instr_count <= instr_count + 16'h0001;
  end
`endif

  assign imem_addr = pc;
  assign OpCode    = instr[OPC_MSB:OPC_LSB];

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed bench for busca_instrucao: reset, fetch/issue timing, next-PC priority, wrap, halt, reset mid-fetch.
module tb_busca_instrucao;

  localparam int PC_W = 8;

  logic            clock = 1'b0;
  logic            reset;
  logic [PC_W-1:0] imem_addr;
  logic            imem_req;
  logic            imem_ack;
  logic [15:0]     imem_data;
  logic [15:0]     instr;
  logic [2:0]      OpCode;
  logic            instr_valid;
  logic            exec_done;
  logic            Halt, Beq, Salto, zero;
  logic [PC_W-1:0] pc;
  logic            halted;
`ifdef FETCH_COUNT_EN
  logic [15:0]     instr_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  busca_instrucao #(.PC_W(PC_W), .RESET_PC(8'h00)) dut (
    .clock       (clock),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_req    (imem_req),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .instr       (instr),
    .OpCode      (OpCode),
    .instr_valid (instr_valid),
    .exec_done   (exec_done),
    .Halt        (Halt),
    .Beq         (Beq),
    .Salto       (Salto),
    .zero        (zero),
    .pc          (pc),
    .halted      (halted)
`ifdef FETCH_COUNT_EN
    ,
    .instr_count (instr_count)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // Waits for a request (bounded), delays the ack, leaves the bench at posedge+1 of the ISSUE cycle.
  task automatic fetch_issue(input logic [15:0] d, input int delay);
    int t;
    t = 0;
    @(negedge clock);
    while (imem_req !== 1'b1 && t < 50) begin
      @(negedge clock);
      t++;
    end
    n_vec++;
    if (imem_req !== 1'b1) begin
      n_err++;
      $display("FAIL fetch_timeout imem_req=%b expected 1", imem_req);
    end
    repeat (delay) @(negedge clock);
    imem_ack  = 1'b1;
    imem_data = d;
    @(posedge clock);
    #1;
    imem_ack  = 1'b0;
    imem_data = 16'h0000;
  endtask

  task automatic exec_instr(input logic h, input logic b, input logic s, input logic z, input int gap);
    repeat (gap) @(negedge clock);
    Halt = h; Beq = b; Salto = s; zero = z;
    exec_done = 1'b1;
    @(posedge clock);
    #1;
    exec_done = 1'b0;
    Halt = 1'b0; Beq = 1'b0; Salto = 1'b0; zero = 1'b0;
  endtask

  task automatic run_instr(input logic [15:0] d, input int delay,
                           input logic h, input logic b, input logic s, input logic z);
    fetch_issue(d, delay);
    exec_instr(h, b, s, z, 2);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    imem_ack = 1'b0; imem_data = 16'h0000; exec_done = 1'b0;
    Halt = 1'b0; Beq = 1'b0; Salto = 1'b0; zero = 1'b0;
    repeat (2) @(negedge clock);
    n_vec++; if (pc !== 8'h00) begin n_err++; $display("FAIL reset_pc got %h want 00", pc); end
    n_vec++; if (imem_addr !== 8'h00) begin n_err++; $display("FAIL reset_addr got %h want 00", imem_addr); end
    n_vec++; if (instr !== 16'h0000) begin n_err++; $display("FAIL reset_instr got %h want 0000", instr); end
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b want 0", imem_req); end
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", instr_valid); end
    n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted got %b want 0", halted); end
`ifdef FETCH_COUNT_EN
    n_vec++; if (instr_count !== 16'h0000) begin n_err++; $display("FAIL reset_count got %h want 0000", instr_count); end
`endif
    reset = 1'b0;
  endtask

  task automatic test_basic_add;
    fetch_issue(16'h4000, 0);
    @(negedge clock);
    n_vec++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL add_valid got %b want 1", instr_valid); end
    n_vec++; if (OpCode !== 3'b010) begin n_err++; $display("FAIL add_opcode got %b want 010", OpCode); end
    n_vec++; if (instr !== 16'h4000) begin n_err++; $display("FAIL add_instr got %h want 4000", instr); end
    n_vec++; if (pc !== 8'h00) begin n_err++; $display("FAIL add_pc_before got %h want 00", pc); end
    @(negedge clock);
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL add_valid_pulse got %b want 0", instr_valid); end
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL add_req_exec got %b want 0", imem_req); end
    exec_instr(1'b0, 1'b0, 1'b0, 1'b0, 1);
    @(negedge clock);
    n_vec++; if (pc !== 8'h01) begin n_err++; $display("FAIL add_pc_after got %h want 01", pc); end
    n_vec++; if (imem_addr !== 8'h01) begin n_err++; $display("FAIL add_addr_after got %h want 01", imem_addr); end
    n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL add_req_after got %b want 1", imem_req); end
  endtask

  task automatic test_beq;
    run_instr(16'h8005, 3, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clock);
    n_vec++; if (pc !== 8'h05) begin n_err++; $display("FAIL beq_setup got %h want 05", pc); end
    run_instr(16'h607D, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clock);
    n_vec++; if (pc !== 8'h03) begin n_err++; $display("FAIL beq_taken got %h want 03", pc); end
    run_instr(16'h8005, 1, 1'b0, 1'b0, 1'b1, 1'b0);
    run_instr(16'h607D, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    n_vec++; if (pc !== 8'h06) begin n_err++; $display("FAIL beq_not_taken got %h want 06", pc); end
  endtask

  task automatic test_salto_priority;
    run_instr(16'h8042, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    @(negedge clock);
    n_vec++; if (pc !== 8'h42) begin n_err++; $display("FAIL salto_priority got %h want 42", pc); end
  endtask

  task automatic test_back_to_back_wrap;
    run_instr(16'h80FF, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clock);
    n_vec++; if (pc !== 8'hFF) begin n_err++; $display("FAIL wrap_setup got %h want ff", pc); end
    run_instr(16'h4000, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    n_vec++; if (pc !== 8'h00) begin n_err++; $display("FAIL wrap_pc got %h want 00", pc); end
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 8'h00)
      begin n_err++; $display("FAIL wrap_refetch req=%b addr=%h want 1/00", imem_req, imem_addr); end
  endtask

  task automatic test_halt;
    run_instr(16'hE000, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      n_vec++;
      if (imem_req !== 1'b0 || halted !== 1'b1 || pc !== 8'h00) begin
        n_err++;
        $display("FAIL halt_hold cyc=%0d req=%b halted=%b pc=%h want 0/1/00", i, imem_req, halted, pc);
      end
      exec_done = (i == 5);
      imem_ack  = (i == 9);
      imem_data = (i == 9) ? 16'h1234 : 16'h0000;
    end
    exec_done = 1'b0; imem_ack = 1'b0; imem_data = 16'h0000;
    @(negedge clock);
    n_vec++; if (instr !== 16'hE000) begin n_err++; $display("FAIL halt_instr got %h want e000", instr); end
`ifdef FETCH_COUNT_EN
    n_vec++; if (instr_count !== 16'd9) begin n_err++; $display("FAIL halt_count got %0d want 9", instr_count); end
`endif
  endtask

  task automatic test_reset_midfetch;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL mid_req_before got %b want 1", imem_req); end
    repeat (2) @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    n_vec++; if (imem_req !== 1'b0 || pc !== 8'h00 || instr !== 16'h0000 || halted !== 1'b0 || instr_valid !== 1'b0)
      begin n_err++; $display("FAIL mid_async req=%b pc=%h instr=%h halted=%b valid=%b want 0/00/0000/0/0",
                              imem_req, pc, instr, halted, instr_valid); end
`ifdef FETCH_COUNT_EN
    n_vec++; if (instr_count !== 16'h0000) begin n_err++; $display("FAIL mid_count_reset got %h want 0000", instr_count); end
`endif
    @(negedge clock);
    imem_ack = 1'b1; imem_data = 16'hA5A5;
    @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1 imem_ack = 1'b0; imem_data = 16'h0000;
    @(negedge clock);
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin n_err++; $display("FAIL mid_refetch req=%b addr=%h want 1/00", imem_req, imem_addr); end
    n_vec++; if (instr !== 16'h0000 || instr_valid !== 1'b0) begin n_err++; $display("FAIL mid_late_ack instr=%h valid=%b want 0000/0", instr, instr_valid); end
    fetch_issue(16'h5001, 0);
    @(negedge clock);
    n_vec++; if (instr !== 16'h5001 || instr_valid !== 1'b1 || OpCode !== 3'b010)
      begin n_err++; $display("FAIL mid_fresh instr=%h valid=%b op=%b want 5001/1/010", instr, instr_valid, OpCode); end
    @(negedge clock);
`ifdef FETCH_COUNT_EN
    n_vec++; if (instr_count !== 16'd1) begin n_err++; $display("FAIL mid_count got %0d want 1", instr_count); end
`endif
    n_vec++; if (pc !== 8'h00) begin n_err++; $display("FAIL mid_pc got %h want 00", pc); end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_beq();
    test_salto_priority();
    test_back_to_back_wrap();
    test_halt();
    test_reset_midfetch();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
